// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// State codes, gain encodings and phase magnitude.
package pll_pkg;

  localparam int PW = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACQ    = 3'd2,
    S_TRACK  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  localparam logic [1:0] GAIN_OFF    = 2'd0;
  localparam logic [1:0] GAIN_NARROW = 2'd1;
  localparam logic [1:0] GAIN_WIDE   = 2'd2;

  // |a| in PW-1 bits; -full-scale saturates to all-ones
  function automatic logic [PW-2:0] sat_abs(
    input logic [PW-1:0] a
  );
    logic [PW-1:0] n;
    n = -a;
    if (!a[PW-1])
      return a[PW-2:0];
    else if (a == {1'b1, {(PW-1){1'b0}}})
      return '1;
    else
      return n[PW-2:0];
  endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// Conditioned phase stream from the phase detector.
// Master drives angle and strobe, slave consumes.
interface pll_lock_seq_if
  import pll_pkg::*;
#(
  parameter int w = PW
) ();

  logic [w-1:0] ang_in;
  logic         strobe_in;

  modport master (output ang_in, output strobe_in);
  modport slave  (input  ang_in, input  strobe_in);

endinterface

// File: rtl/sat_dwell_cnt.sv
// Saturating up-counter with clear, increment and
// a terminal-count compare against a runtime value.
module sat_dwell_cnt #(
  parameter int cw = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic [cw-1:0] term,
  output logic          hit
);

  logic [cw-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/pll_lock_seq.sv
// PLL acquisition/lock sequencer: clear, acquire,
// track, locked; drives loop gain and lock status.
module pll_lock_seq
  import pll_pkg::*;
#(
  parameter int w            = PW,
  parameter int cw           = 12,
  parameter int clear_len    = 16,
  parameter int acq_dwell    = 256,
  parameter int acq_timeout  = 4000,
  parameter int lock_count   = 1024,
  parameter int unlock_count = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  pll_lock_seq_if.slave  ph,
  input  logic [w-2:0]   lock_thresh,
  output logic [1:0]     gain_sel,
  output logic           int_clear,
  output logic           locked,
  output logic           lol_pulse,
  output logic [7:0]     retry_cnt,
  output logic [2:0]     state_out,
  output logic           strobe_out
);

  localparam logic [cw-1:0] T_CLR  = cw'(clear_len - 1);
  localparam logic [cw-1:0] T_DWL  = cw'(acq_dwell - 1);
  localparam logic [cw-1:0] T_TOUT = cw'(acq_timeout - 1);
  localparam logic [cw-1:0] T_LOCK = cw'(lock_count - 1);
  localparam logic [cw-1:0] T_ULK  = cw'(unlock_count - 1);

  state_t        state, nxt;
  logic          clipped, in_win;
  logic [w-2:0]  mag;
  logic [cw-1:0] term;
  logic          c_hit, t_hit;
  logic          c_clr, c_inc, chg;
  logic          t_clr, t_inc;
  logic          retry_inc, lol;

  assign clipped =
    (ph.ang_in == {1'b0, {(w-1){1'b1}}}) ||
    (ph.ang_in == {1'b1, {(w-1){1'b0}}});
  assign mag    = sat_abs(ph.ang_in);
  assign in_win = (mag < lock_thresh);

  always_comb begin
    term = '0;
    unique case (state)
      S_CLEAR:  term = T_CLR;
      S_ACQ:    term = T_DWL;
      S_TRACK:  term = T_LOCK;
      S_LOCKED: term = T_ULK;
      default:  term = '0;
    endcase
  end

  always_comb begin
    nxt       = state;
    c_clr     = 1'b0;
    c_inc     = 1'b0;
    retry_inc = 1'b0;
    lol       = 1'b0;
    if (!enable) begin
      nxt = S_IDLE;
    end else if (ph.strobe_in) begin
      unique case (state)
        S_IDLE: nxt = S_CLEAR;
        S_CLEAR: begin
          if (c_hit) nxt = S_CLEAR == state ? S_ACQ : state;
          else       c_inc = 1'b1;
        end
        // dwell success beats timeout on the same strobe
        S_ACQ: begin
          if (!clipped && c_hit) begin
            nxt = S_TRACK;
          end else if (t_hit) begin
            nxt       = S_CLEAR;
            retry_inc = 1'b1;
          end else if (clipped) begin
            c_clr = 1'b1;
          end else begin
            c_inc = 1'b1;
          end
        end
        S_TRACK: begin
          if (clipped)     nxt   = S_ACQ;
          else if (!in_win) c_clr = 1'b1;
          else if (c_hit)  nxt   = S_LOCKED;
          else             c_inc = 1'b1;
        end
        S_LOCKED: begin
          if (clipped) begin
            nxt = S_ACQ;
            lol = 1'b1;
          end else if (in_win) begin
            c_clr = 1'b1;
          end else if (c_hit) begin
            nxt = S_ACQ;
            lol = 1'b1;
          end else begin
            c_inc = 1'b1;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign chg   = (nxt != state);
  assign t_clr = chg || (state != S_ACQ);
  assign t_inc = enable && ph.strobe_in &&
                 (state == S_ACQ);

  sat_dwell_cnt #(.cw(cw)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (c_clr || chg),
    .inc   (c_inc),
    .term  (term),
    .hit   (c_hit)
  );

  sat_dwell_cnt #(.cw(cw)) u_tout (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .inc   (t_inc),
    .term  (T_TOUT),
    .hit   (t_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gain_sel   <= GAIN_OFF;
      int_clear  <= 1'b1;
      locked     <= 1'b0;
      lol_pulse  <= 1'b0;
      retry_cnt  <= '0;
      strobe_out <= 1'b0;
    end else begin
      state      <= nxt;
      int_clear  <= (nxt == S_IDLE) ||
                    (nxt == S_CLEAR);
      locked     <= (nxt == S_LOCKED);
      lol_pulse  <= lol;
      strobe_out <= ph.strobe_in;
      if (retry_inc && retry_cnt != 8'hFF)
        retry_cnt <= retry_cnt + 8'd1;
      unique case (nxt)
        S_ACQ:    gain_sel <= GAIN_WIDE;
        S_TRACK,
        S_LOCKED: gain_sel <= GAIN_NARROW;
        default:  gain_sel <= GAIN_OFF;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: main instance with
// default parameters plus a short-timeout instance.
module tb_pll_lock_seq;

  localparam logic [16:0] PFS = 17'h0FFFF;
  localparam logic [16:0] NFS = 17'h10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, en2;
  logic [15:0] lock_thresh;
  logic [1:0]  gain_sel, g2;
  logic        int_clear, locked, lol_pulse;
  logic        ic2, lk2, lol2;
  logic [7:0]  retry_cnt, rc2;
  logic [2:0]  state_out, st2;
  logic        strobe_out, so2;

  int checks = 0;
  int errors = 0;
  int gap = 4;

  pll_lock_seq_if #(.w(17)) ph ();
  pll_lock_seq_if #(.w(17)) ph2 ();

  pll_lock_seq dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ph          (ph),
    .lock_thresh (lock_thresh),
    .gain_sel    (gain_sel),
    .int_clear   (int_clear),
    .locked      (locked),
    .lol_pulse   (lol_pulse),
    .retry_cnt   (retry_cnt),
    .state_out   (state_out),
    .strobe_out  (strobe_out)
  );

  pll_lock_seq #(
    .clear_len   (2),
    .acq_timeout (20)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .enable      (en2),
    .ph          (ph2),
    .lock_thresh (lock_thresh),
    .gain_sel    (g2),
    .int_clear   (ic2),
    .locked      (lk2),
    .lol_pulse   (lol2),
    .retry_cnt   (rc2),
    .state_out   (st2),
    .strobe_out  (so2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic s,
                      input logic [16:0] a);
    ph.strobe_in = s;
    ph.ang_in    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic s,
                       input logic [16:0] a);
    ph2.strobe_in = s;
    ph2.ang_in    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic strb(input int n,
                      input logic [16:0] a);
    for (int i = 0; i < n; i++) begin
      step(1'b1, a);
      for (int g = 1; g < gap; g++) step(1'b0, a);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    en2 = 1'b0;
    lock_thresh = 16'd256;
    ph2.strobe_in = 1'b0;
    ph2.ang_in = '0;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("rst_state", state_out, 0);
    chk("rst_gain", gain_sel, 0);
    chk("rst_iclr", int_clear, 1);
    chk("rst_lock", locked, 0);
    chk("rst_lol", lol_pulse, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_sout", strobe_out, 0);
    reset = 1'b0;
    enable = 1'b1;

    step(1'b1, '0);
    chk("sout", strobe_out, 1);
    chk("to_clear", state_out, 1);
    chk("clear_iclr", int_clear, 1);
    repeat (3) step(1'b0, '0);
    strb(15, '0);
    chk("clear15", state_out, 1);
    strb(1, '0);
    chk("to_acq", state_out, 2);
    chk("acq_gain", gain_sel, 2);
    chk("acq_iclr", int_clear, 0);
    strb(255, '0);
    chk("acq255", state_out, 2);
    strb(1, '0);
    chk("to_track", state_out, 3);
    chk("track_gain", gain_sel, 1);
    strb(1023, '0);
    chk("track1023", locked, 0);
    step(1'b1, '0);
    chk("lock", locked, 1);
    chk("lock_st", state_out, 4);

    gap = 1;
    strb(63, 17'd300);
    strb(1, '0);
    chk("ulk63_hold", locked, 1);
    strb(63, 17'd300);
    chk("ulk63b", locked, 1);
    chk("ulk63b_lol", lol_pulse, 0);
    step(1'b1, 17'd300);
    chk("ulk64", locked, 0);
    chk("ulk64_lol", lol_pulse, 1);
    chk("ulk64_st", state_out, 2);
    step(1'b0, '0);
    chk("lol_one", lol_pulse, 0);

    // mag of -fs+1 is 0xFFFF: not inside a 0xFFFF window
    lock_thresh = 16'hFFFF;
    strb(256, '0);
    chk("re_track", state_out, 3);
    strb(1022, '0);
    step(1'b1, 17'h10001);
    strb(1, '0);
    chk("mag_out", state_out, 3);
    strb(1022, '0);
    chk("mag_pre", state_out, 3);
    step(1'b1, '0);
    chk("relock", state_out, 4);
    step(1'b1, NFS);
    chk("nfs_st", state_out, 2);
    chk("nfs_lol", lol_pulse, 1);
    chk("nfs_lock", locked, 0);
    lock_thresh = 16'd256;

    enable = 1'b0;
    step(1'b0, '0);
    chk("dis_st", state_out, 0);
    enable = 1'b1;
    strb(1, '0);
    strb(16, '0);
    chk("r_acq", state_out, 2);
    for (int i = 0; i < 3999; i++)
      step(1'b1, (i % 100 == 99) ? PFS : '0);
    chk("tout_pre", state_out, 2);
    step(1'b1, '0);
    chk("tout_st", state_out, 1);
    chk("tout_retry", retry_cnt, 1);
    chk("tout_iclr", int_clear, 1);
    strb(16, '0);
    chk("c_acq", state_out, 2);
    for (int i = 0; i < 3999; i++)
      step(1'b1, ((i < 3700 && i % 100 == 99) ||
                  i == 3743) ? PFS : '0);
    chk("coin_pre", state_out, 2);
    step(1'b1, '0);
    chk("coin_st", state_out, 3);
    chk("coin_retry", retry_cnt, 1);

    enable = 1'b0;
    step(1'b0, '0);
    chk("en_st", state_out, 0);
    chk("en_iclr", int_clear, 1);
    chk("en_gain", gain_sel, 0);
    chk("en_retry", retry_cnt, 1);

    enable = 1'b1;
    strb(1, '0);
    strb(16, '0);
    strb(256, '0);
    strb(1024, '0);
    chk("pre_rst", state_out, 4);
    reset = 1'b1;
    step(1'b1, 17'd300);
    chk("mr_state", state_out, 0);
    chk("mr_gain", gain_sel, 0);
    chk("mr_iclr", int_clear, 1);
    chk("mr_lock", locked, 0);
    chk("mr_lol", lol_pulse, 0);
    chk("mr_retry", retry_cnt, 0);
    chk("mr_sout", strobe_out, 0);
    reset = 1'b0;
    step(1'b0, '0);

    en2 = 1'b1;
    step2(1'b1, PFS);
    for (int i = 0; i < 254 * 22; i++)
      step2(1'b1, PFS);
    chk("sat254", rc2, 254);
    for (int i = 0; i < 46 * 22; i++)
      step2(1'b1, PFS);
    chk("sat255", rc2, 255);
    chk("sat_st", st2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
